// File: rtl/mem_arbiter.sv
// Arbitrates one single-port multi-cycle memory between the fetch (I) and load/store (D) ports.
// Each granted access holds the bus for LAT cycles and returns a one-cycle valid pulse.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LAT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    output logic              i_valid,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    localparam logic [3:0] CntInit = 4'(LAT - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [3:0]          r_cnt;
    logic                r_last_d;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_i_data;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_i_valid;
    logic                r_d_valid;

    logic w_i_done;
    logic w_d_done;
    logic w_decide;
    logic w_i_pend;
    logic w_d_pend;
    logic w_grant_i;
    logic w_grant_d;

    always_comb begin
        w_i_done = (r_state == StBusyI) && (r_cnt == 4'd0);
        w_d_done = (r_state == StBusyD) && (r_cnt == 4'd0);
        w_decide = (r_state == StIdle) || w_i_done || w_d_done;
        // A port's request is still asserted while it completes and during its valid cycle;
        // it is masked then so the same access is never granted twice.
        w_i_pend = i_req && !r_i_valid && !w_i_done;
        w_d_pend = d_req && !r_d_valid && !w_d_done;
        w_grant_i = w_decide && w_i_pend && (!w_d_pend || r_last_d);
        w_grant_d = w_decide && w_d_pend && (!w_i_pend || !r_last_d);
    end

    always_comb begin
        w_state_next = r_state;
        if (w_grant_i) begin
            w_state_next = StBusyI;
        end else if (w_grant_d) begin
            w_state_next = StBusyD;
        end else if (w_decide) begin
            w_state_next = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_last_d    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_data    <= '0;
            r_d_rdata   <= '0;
            r_i_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
        end else begin
            r_i_valid <= w_i_done;
            r_d_valid <= w_d_done;
            if (w_i_done) begin
                r_i_data <= mem_rdata;
            end
            if (w_d_done && !r_mem_wr) begin
                r_d_rdata <= mem_rdata;
            end
            if (w_grant_i) begin
                r_cnt      <= CntInit;
                r_last_d   <= 1'b0;
                r_mem_wr   <= 1'b0;
                r_mem_addr <= i_addr;
            end else if (w_grant_d) begin
                r_cnt       <= CntInit;
                r_last_d    <= 1'b1;
                r_mem_wr    <= d_wr;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else if ((r_state != StIdle) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign i_data    = r_i_data;
    assign i_valid   = r_i_valid;
    assign i_stall   = i_req && !r_i_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign d_stall   = d_req && !r_d_valid;
    assign mem_en    = (r_state != StIdle);
    assign mem_wr    = r_mem_wr && (r_state == StBusyD);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-exact bus/latency checks plus an ordered
// scoreboard of expected completions compared whenever a valid pulse appears.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic        i_valid;
    logic        i_stall;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int n_checks;
    int n_pass;
    int bus_cnt;
    logic [17:0] sb_q[$];

    mem_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .LAT   (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_stall  (i_stall),
        .d_req    (d_req),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .d_stall  (d_stall),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return a ^ 16'hA5D3;
    endfunction

    // Memory model: read data is only meaningful in the last cycle of each LAT-cycle access.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_cnt <= 0;
        end else if (mem_en) begin
            bus_cnt <= (bus_cnt == LAT - 1) ? 0 : bus_cnt + 1;
        end else begin
            bus_cnt <= 0;
        end
    end
    assign mem_rdata = (mem_en && bus_cnt == LAT - 1) ? mem_fn(mem_addr) : 16'hDEAD;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [5:0] flags, input logic [15:0] addr);
        check_eq(tag, 64'({mem_en, mem_wr, i_valid, d_valid, i_stall, d_stall,
                           mem_addr & {16{mem_en}}}),
                 64'({flags, addr}));
    endtask

    task automatic sb_push(input logic port_d, input logic [15:0] data);
        sb_q.push_back({1'b1, port_d, data});
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [17:0] exp;
        if (rst_n && (i_valid || d_valid)) begin
            check_eq("one_valid", 64'(i_valid & d_valid), 64'd0);
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 18'd0;
            if (i_valid) begin
                check_eq("sb_i", 64'({1'b1, 1'b0, i_data}), 64'(exp));
            end else begin
                check_eq("sb_d", 64'({1'b1, 1'b1, d_rdata}), 64'(exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ni;
        int nd;
        int en_cyc;
        logic en_seen;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_wr     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;

        // Reset and idle
        #1;
        check_eq("reset_outs", 64'({i_data, d_rdata, i_valid, d_valid, i_stall, d_stall,
                                    mem_en, mem_wr}), 64'd0);
        check_eq("reset_bus", 64'({mem_addr, mem_wdata}), 64'd0);
        tick();
        rst_n = 1'b1;
        en_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            en_seen = en_seen | mem_en;
        end
        check_eq("idle_no_en", 64'(en_seen), 64'd0);

        // Fetch only
        i_req  = 1'b1;
        i_addr = 16'h0010;
        sb_push(1'b0, 16'hA5C3);
        #1;
        expect_cyc("fetch_c0", 6'b000010, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_cyc($sformatf("fetch_c%0d", k), 6'b100010, 16'h0010);
        end
        tick();
        expect_cyc("fetch_c5", 6'b001000, 16'h0000);
        check_eq("fetch_data", 64'(i_data), 64'h0000_A5C3);
        i_req = 1'b0;
        tick();

        // Simultaneous requests from reset: D wins the first tie
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        i_req  = 1'b1;
        i_addr = 16'h0040;
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h0200;
        sb_push(1'b1, mem_fn(16'h0200));
        sb_push(1'b0, mem_fn(16'h0040));
        #1;
        expect_cyc("both_c0", 6'b000011, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_cyc($sformatf("both_c%0d", k), 6'b100011, 16'h0200);
        end
        tick();
        expect_cyc("both_c5", 6'b100110, 16'h0040);
        d_req = 1'b0;
        for (int k = 6; k <= 8; k++) begin
            tick();
            expect_cyc($sformatf("both_c%0d", k), 6'b100010, 16'h0040);
        end
        tick();
        expect_cyc("both_c9", 6'b001000, 16'h0000);
        i_req = 1'b0;
        tick();

        // Store: d_rdata keeps the earlier load result
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0300;
        d_wdata = 16'h1234;
        sb_push(1'b1, mem_fn(16'h0200));
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_cyc($sformatf("store_c%0d", k), 6'b110001, 16'h0300);
        end
        check_eq("store_wdata", 64'(mem_wdata), 64'h1234);
        tick();
        expect_cyc("store_c5", 6'b000100, 16'h0000);
        d_req = 1'b0;
        d_wr  = 1'b0;
        tick();

        // Both held for 6 accesses: last grant was D, so I goes first and they alternate
        i_req  = 1'b1;
        i_addr = 16'h0100;
        d_req  = 1'b1;
        d_addr = 16'h0280;
        for (int k = 0; k < 3; k++) begin
            sb_push(1'b0, mem_fn(16'h0100 + 16'(k)));
            sb_push(1'b1, mem_fn(16'h0280 + 16'(k)));
        end
        ni = 0;
        nd = 0;
        en_cyc = 0;
        for (int k = 0; k < 80 && !(ni == 3 && nd == 3); k++) begin
            tick();
            if (mem_en) en_cyc++;
            if (i_valid) begin
                ni++;
                if (ni == 3) i_req = 1'b0;
                else i_addr = 16'h0100 + 16'(ni);
            end
            if (d_valid) begin
                nd++;
                if (nd == 3) d_req = 1'b0;
                else d_addr = 16'h0280 + 16'(nd);
            end
        end
        check_eq("alt_i_count", 64'(ni), 64'd3);
        check_eq("alt_d_count", 64'(nd), 64'd3);
        check_eq("alt_en_cycles", 64'(en_cyc), 64'd24);
        tick();

        // Reset in cycle 2 of a fetch aborts it; held request restarts a full access
        i_req  = 1'b1;
        i_addr = 16'h0050;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", 64'({i_data, d_rdata, i_valid, d_valid, mem_en, mem_wr}),
                 64'd0);
        check_eq("rst_mid_bus", 64'({mem_addr, mem_wdata}), 64'd0);
        tick();
        rst_n = 1'b1;
        sb_push(1'b0, mem_fn(16'h0050));
        for (int k = 1; k <= 4; k++) begin
            tick();
            expect_cyc($sformatf("restart_c%0d", k), 6'b100010, 16'h0050);
        end
        tick();
        expect_cyc("restart_c5", 6'b001000, 16'h0000);
        i_req = 1'b0;

        repeat (3) tick();
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
